playseq_jogador_automatico: RTL and testbench

Automatic player for the PlaySeq game, and the other end of the game's LED/button interface. The game shows a sequence on `leds`; this block captures it and presses the same sequence back on the game's `botoes` input. Each round of a match repeats that capture and replay. It is used for hands-free regression of the game and for board demos. Error injection lets a bench force a loss at a chosen position.

---
 rtl/playseq_jogador_automatico.sv | 249 ++++++++++++++++++++++++
 tb/tb_playseq_jogador_automatico.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/playseq_jogador_automatico.sv
// playseq_jogador_automatico
// Automatic player for the PlaySeq game. It captures the sequence that the
// game flashes on its LEDs, then presses the same sequence back on the game's
// buttons. Each round of a match repeats this capture and replay.
//
// Ports
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   habilita        : arms the player; low forces OCIOSO on the next edge
//   leds[3:0]       : game LED outputs, sampled every cycle
//   errar           : enables error injection during replay
//   posicao_erro    : replay index whose press is corrupted (rotate-left)
//   botoes[3:0]     : registered button drive to the game
//   ocupado         : high while in APERTA or PAUSA
//   concluido       : one-cycle pulse after the last pause of a replay
//   estouro         : sticky; a flash was dropped because the buffer was full
//   db_tamanho      : entries captured this round
//   db_rodadas      : completed replays, wraps 15 -> 0
//   db_estado       : state code
//
// Handshake: there is no valid/ready pair here. A "valid flash" is a cycle in
// which leds has exactly one bit set; every such cycle sampled in ESPERA_LED
// or SILENCIO is a capture attempt, all other non-zero patterns are ignored.
module playseq_jogador_automatico #(
  parameter int PROFUNDIDADE = 16,
  parameter int T_APERTO     = 4,
  parameter int T_PAUSA      = 4,
  parameter int T_SILENCIO   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] leds,
  input  logic       errar,
  input  logic [3:0] posicao_erro,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       concluido,
  output logic       estouro,
  output logic [4:0] db_tamanho,
  output logic [3:0] db_rodadas,
  output logic [2:0] db_estado
);

  localparam logic [2:0] OCIOSO     = 3'd0;
  localparam logic [2:0] ESPERA_LED = 3'd1;
  localparam logic [2:0] CAPTURA    = 3'd2;
  localparam logic [2:0] SILENCIO   = 3'd3;
  localparam logic [2:0] APERTA     = 3'd4;
  localparam logic [2:0] PAUSA      = 3'd5;
  localparam logic [2:0] REARMA     = 3'd6;

  localparam int T_MAX0 = (T_APERTO > T_PAUSA) ? T_APERTO : T_PAUSA;
  localparam int T_MAX  = (T_MAX0 > T_SILENCIO) ? T_MAX0 : T_SILENCIO;
  localparam int CW     = $clog2(T_MAX + 1);
  localparam int IW     = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d;
  logic [4:0]    tam_q, tam_d;
  logic [3:0]    rod_q, rod_d;
  logic [3:0]    botoes_q, botoes_d;
  logic          concluido_q, concluido_d;
  logic          estouro_q, estouro_d;
  logic [3:0]    mem_q [PROFUNDIDADE];
  logic          we;

  logic          flash_ok;
  logic          leds_zero;
  logic          cheio;
  logic [4:0]    idx_n;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign flash_ok  = (leds != 4'd0) && ((leds & (leds - 4'd1)) == 4'd0);
  assign leds_zero = (leds == 4'd0);
  assign cheio     = (tam_q == 5'(PROFUNDIDADE));
  assign idx_n     = idx_q + 5'd1;

  function automatic logic [3:0] press_val(input logic [3:0] b, input logic corrupt);
    press_val = corrupt ? {b[2:0], b[3]} : b;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tam_d       = tam_q;
    rod_d       = rod_q;
    botoes_d    = botoes_q;
    concluido_d = 1'b0;
    estouro_d   = estouro_q;
    we          = 1'b0;

    case (state_q)
      OCIOSO: begin
        botoes_d  = 4'd0;
        tam_d     = 5'd0;
        estouro_d = 1'b0;
        cnt_d     = '0;
        idx_d     = 5'd0;
        if (habilita) state_d = ESPERA_LED;
      end

      ESPERA_LED: begin
        if (flash_ok) begin
          if (cheio) estouro_d = 1'b1;
          else begin
            we    = 1'b1;
            tam_d = tam_q + 5'd1;
          end
          state_d = CAPTURA;
        end
      end

      CAPTURA: begin
        if (leds_zero) begin
          if (T_SILENCIO == 1) begin
            state_d  = APERTA;
            idx_d    = 5'd0;
            cnt_d    = '0;
            botoes_d = press_val(mem_q[0], errar && (posicao_erro == 4'd0));
          end else begin
            state_d = SILENCIO;
            cnt_d   = CW'(1);
          end
        end
      end

      SILENCIO: begin
        if (leds_zero) begin
          if (cnt_q + CW'(1) == CW'(T_SILENCIO)) begin
            // Press is loaded on the same edge as the state change so that
            // botoes and ocupado rise together.
            state_d  = APERTA;
            idx_d    = 5'd0;
            cnt_d    = '0;
            botoes_d = press_val(mem_q[0], errar && (posicao_erro == 4'd0));
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (flash_ok) begin
          // A full buffer drops the flash but still follows it into CAPTURA.
          if (cheio) estouro_d = 1'b1;
          else begin
            we    = 1'b1;
            tam_d = tam_q + 5'd1;
          end
          state_d = CAPTURA;
        end else begin
          cnt_d = '0;
        end
      end

      APERTA: begin
        if (cnt_q == CW'(T_APERTO - 1)) begin
          state_d  = PAUSA;
          botoes_d = 4'd0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PAUSA: begin
        if (cnt_q == CW'(T_PAUSA - 1)) begin
          cnt_d = '0;
          if (idx_n < tam_q) begin
            state_d  = APERTA;
            idx_d    = idx_n;
            botoes_d = press_val(mem_q[idx_n[IW-1:0]],
                                 errar && (idx_n == {1'b0, posicao_erro}));
          end else begin
            state_d     = REARMA;
            concluido_d = 1'b1;
            rod_d       = rod_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      REARMA: begin
        // The game echoes our presses on its LEDs; only a full silence window
        // ends the round, so the echo is never captured.
        if (leds_zero) begin
          if (cnt_q + CW'(1) == CW'(T_SILENCIO)) begin
            state_d   = ESPERA_LED;
            tam_d     = 5'd0;
            estouro_d = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: state_d = OCIOSO;
    endcase

    if (!habilita) begin
      state_d     = OCIOSO;
      botoes_d    = 4'd0;
      tam_d       = 5'd0;
      estouro_d   = 1'b0;
      cnt_d       = '0;
      idx_d       = 5'd0;
      concluido_d = 1'b0;
      we          = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= OCIOSO;
      cnt_q       <= '0;
      idx_q       <= 5'd0;
      tam_q       <= 5'd0;
      rod_q       <= 4'd0;
      botoes_q    <= 4'd0;
      concluido_q <= 1'b0;
      estouro_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tam_q       <= tam_d;
      rod_q       <= rod_d;
      botoes_q    <= botoes_d;
      concluido_q <= concluido_d;
      estouro_q   <= estouro_d;
    end
  end

  // Buffer contents need no reset: db_tamanho gates every read.
  always_ff @(posedge clock) begin
    if (!reset && we) mem_q[tam_q[IW-1:0]] <= leds;
  end

  assign botoes     = botoes_q;
  assign ocupado    = (state_q == APERTA) || (state_q == PAUSA);
  assign concluido  = concluido_q;
  assign estouro    = estouro_q;
  assign db_tamanho = tam_q;
  assign db_rodadas = rod_q;
  assign db_estado  = state_q;

endmodule

// File: tb/tb_playseq_jogador_automatico.sv
module tb_playseq_jogador_automatico;

  localparam int T_APERTO = 4;
  localparam int T_PAUSA  = 4;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic [3:0] leds;
  logic       errar;
  logic [3:0] posicao_erro;
  logic [3:0] botoes;
  logic       ocupado;
  logic       concluido;
  logic       estouro;
  logic [4:0] db_tamanho;
  logic [3:0] db_rodadas;
  logic [2:0] db_estado;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];

  playseq_jogador_automatico dut (
    .clock        (clock),
    .reset        (reset),
    .habilita     (habilita),
    .leds         (leds),
    .errar        (errar),
    .posicao_erro (posicao_erro),
    .botoes       (botoes),
    .ocupado      (ocupado),
    .concluido    (concluido),
    .estouro      (estouro),
    .db_tamanho   (db_tamanho),
    .db_rodadas   (db_rodadas),
    .db_estado    (db_estado)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    leds = v;
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
    n_tests++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Walks the replay against exp_q, starting at the first press cycle,
  // and ends on the cycle where concluido must be high.
  task automatic check_replay();
    for (int k = 0; k < exp_q.size(); k++) begin
      chk("ocupado_press", {7'd0, ocupado}, 8'd1);
      for (int c = 0; c < T_APERTO; c++) begin
        chk("press", {4'd0, botoes}, {4'd0, exp_q[k]});
        if (c < T_APERTO - 1 || k < exp_q.size()) chk("concl_low", {7'd0, concluido}, 8'd0);
        step();
      end
      for (int c = 0; c < T_PAUSA; c++) begin
        chk("pause", {4'd0, botoes}, 8'd0);
        step();
      end
    end
    chk("concluido", {7'd0, concluido}, 8'd1);
    chk("estado_rearma", {5'd0, db_estado}, 8'd6);
  endtask

  initial begin
    int seen;
    reset = 1'b1; habilita = 1'b0; leds = 4'd0; errar = 1'b0; posicao_erro = 4'd0;
    step(); step();

    // Reset wins over habilita
    habilita = 1'b1;
    step();
    chk("rst_estado", {5'd0, db_estado}, 8'd0);
    chk("rst_botoes", {4'd0, botoes}, 8'd0);
    chk("rst_ocupado", {7'd0, ocupado}, 8'd0);
    chk("rst_concluido", {7'd0, concluido}, 8'd0);
    chk("rst_estouro", {7'd0, estouro}, 8'd0);
    chk("rst_tamanho", {3'd0, db_tamanho}, 8'd0);
    chk("rst_rodadas", {4'd0, db_rodadas}, 8'd0);
    reset = 1'b0;
    step();
    chk("arm_estado", {5'd0, db_estado}, 8'd1);

    // Basic round
    drive(4'b0001, 3);
    chk("t1_tam1", {3'd0, db_tamanho}, 8'd1);
    chk("t1_captura", {5'd0, db_estado}, 8'd2);
    drive(4'b0000, 2);
    chk("t1_silencio", {5'd0, db_estado}, 8'd3);
    drive(4'b0100, 3);
    chk("t1_tam2", {3'd0, db_tamanho}, 8'd2);
    drive(4'b0000, 8);
    exp_q = {4'b0001, 4'b0100};
    check_replay();
    chk("t1_rodadas", {4'd0, db_rodadas}, 8'd1);
    chk("t1_tam_rearma", {3'd0, db_tamanho}, 8'd2);
    leds = 4'd0;
    step();
    chk("t1_concl_pulse", {7'd0, concluido}, 8'd0);
    repeat (7) step();
    chk("t1_espera", {5'd0, db_estado}, 8'd1);
    chk("t1_tam_clr", {3'd0, db_tamanho}, 8'd0);

    // Error injection at index 1
    errar = 1'b1; posicao_erro = 4'd1;
    drive(4'b0001, 3); drive(4'b0000, 2); drive(4'b0100, 3); drive(4'b0000, 8);
    exp_q = {4'b0001, 4'b1000};
    check_replay();
    chk("t2_rodadas", {4'd0, db_rodadas}, 8'd2);
    errar = 1'b0; posicao_erro = 4'd0;

    // Echo swallowed in REARMA
    drive(4'b0100, 5);
    chk("echo_tam", {3'd0, db_tamanho}, 8'd2);
    chk("echo_estado", {5'd0, db_estado}, 8'd6);
    drive(4'b0000, 8);
    chk("echo_espera", {5'd0, db_estado}, 8'd1);
    chk("echo_tam_clr", {3'd0, db_tamanho}, 8'd0);
    drive(4'b0010, 2);
    chk("echo_new_tam", {3'd0, db_tamanho}, 8'd1);
    drive(4'b0000, 8);
    exp_q = {4'b0010};
    check_replay();
    chk("echo_rodadas", {4'd0, db_rodadas}, 8'd3);
    drive(4'b0000, 8);

    // Overflow: 17 flashes into a 16-entry buffer
    exp_q = {};
    for (int k = 0; k < 17; k++) begin
      logic [3:0] f;
      f = 4'(1 << (k % 4));
      if (k < 16) exp_q.push_back(f);
      drive(f, 1);
      if (k < 16) drive(4'b0000, 1);
    end
    drive(4'b0000, 8);
    chk("ovf_estouro", {7'd0, estouro}, 8'd1);
    chk("ovf_tam", {3'd0, db_tamanho}, 8'd16);
    check_replay();
    chk("ovf_rodadas", {4'd0, db_rodadas}, 8'd4);
    chk("ovf_sticky", {7'd0, estouro}, 8'd1);
    drive(4'b0000, 8);
    chk("ovf_espera", {5'd0, db_estado}, 8'd1);
    chk("ovf_clr", {7'd0, estouro}, 8'd0);

    // Invalid patterns amid silence
    drive(4'b0001, 2);
    drive(4'b0000, 7);
    chk("inv_sil7", {5'd0, db_estado}, 8'd3);
    drive(4'b0011, 1);
    chk("inv_nocap1", {3'd0, db_tamanho}, 8'd1);
    drive(4'b0000, 7);
    chk("inv_restart", {5'd0, db_estado}, 8'd3);
    drive(4'b1111, 1);
    drive(4'b0000, 2);
    drive(4'b1000, 2);
    chk("inv_tam", {3'd0, db_tamanho}, 8'd2);
    drive(4'b0000, 8);
    exp_q = {4'b0001, 4'b1000};
    check_replay();
    chk("inv_rodadas", {4'd0, db_rodadas}, 8'd5);
    drive(4'b0000, 8);

    // Drop habilita in the second APERTA cycle
    drive(4'b0001, 2);
    drive(4'b0000, 8);
    chk("hab_press1", {4'd0, botoes}, 8'd1);
    step();
    chk("hab_press2", {4'd0, botoes}, 8'd1);
    chk("hab_aperta", {5'd0, db_estado}, 8'd4);
    habilita = 1'b0;
    step();
    chk("hab_botoes", {4'd0, botoes}, 8'd0);
    chk("hab_estado", {5'd0, db_estado}, 8'd0);
    chk("hab_tam", {3'd0, db_tamanho}, 8'd0);
    chk("hab_ocupado", {7'd0, ocupado}, 8'd0);
    chk("hab_rodadas", {4'd0, db_rodadas}, 8'd5);
    seen = 0;
    repeat (40) begin
      if (concluido) seen++;
      step();
    end
    chk("hab_no_concl", 8'(seen), 8'd0);

    // Reset mid-replay
    habilita = 1'b1;
    step();
    chk("rearm_espera", {5'd0, db_estado}, 8'd1);
    drive(4'b0100, 2);
    drive(4'b0000, 8);
    chk("mid_press", {4'd0, botoes}, 8'd4);
    reset = 1'b1;
    step();
    chk("mid_rst_botoes", {4'd0, botoes}, 8'd0);
    chk("mid_rst_estado", {5'd0, db_estado}, 8'd0);
    chk("mid_rst_rodadas", {4'd0, db_rodadas}, 8'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
